// File: rtl/omsp_dma_ctrl.sv
// rtl/omsp_dma_ctrl.sv - openMSP430 memory-to-memory DMA controller; byte transfers enabled by `OMSP_DMA_BYTE_MODE_EN
module omsp_dma_ctrl #(
  parameter logic [14:0] BASE_ADDR = 15'h0090
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        dbg_freeze,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp,
  output logic        irq_dma
);

  typedef enum logic [1:0] {IDLE, RD, RDCAP, WR} state_t;
  state_t state;

  logic        ie, src_inc, dst_inc, prio, busy, done, err, abort_pend;
  logic        byte_mode;
  logic [15:0] src_reg, dst_reg, cnt_reg;
  logic [15:0] src_w, dst_w, remain;

  logic        reg_sel, ctrl_wr_lo, ctrl_wr_hi, start_req, abort_req, halt;
  logic [2:0]  reg_off;
  logic [15:0] step, src_next, dst_next;
  logic [7:0]  rd_byte;
  logic        unused_bits;

  assign reg_sel    = per_en && (per_addr[13:3] == BASE_ADDR[14:4]);
  assign reg_off    = per_addr[2:0];
  assign ctrl_wr_lo = reg_sel && (reg_off == 3'd0) && per_we[0];
  assign ctrl_wr_hi = reg_sel && (reg_off == 3'd0) && per_we[1];
  assign start_req  = ctrl_wr_lo && per_din[0];
  assign abort_req  = ctrl_wr_lo && per_din[6];
  assign halt       = abort_pend || abort_req;

  assign step     = byte_mode ? 16'd1 : 16'd2;
  assign src_next = src_w + (src_inc ? step : 16'd0);
  assign dst_next = dst_w + (dst_inc ? step : 16'd0);
  assign rd_byte  = src_w[0] ? dma_dout[15:8] : dma_dout[7:0];

  assign dma_priority = dma_en & prio;
  assign irq_dma      = ie & (done | err);
  assign unused_bits  = ^{per_din[15:11], per_din[8:7], per_din[4]};

`ifdef OMSP_DMA_BYTE_MODE_EN
  logic byte_q;
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)        byte_q <= 1'b0;
    else if (ctrl_wr_lo) byte_q <= per_din[4];
  end
  assign byte_mode = byte_q;
`else
  assign byte_mode = 1'b0;
`endif

  function automatic logic [15:0] wmerge(input logic [15:0] old, input logic [15:0] d,
                                         input logic [1:0] we);
    wmerge = {we[1] ? d[15:8] : old[15:8], we[0] ? d[7:0] : old[7:0]};
  endfunction

  always_comb begin
    per_dout = 16'h0000;
    if (reg_sel) begin
      case (reg_off)
        3'd0:    per_dout = {5'b0, err, done, busy, 2'b00, prio, byte_mode, dst_inc, src_inc, ie, 1'b0};
        3'd1:    per_dout = src_reg;
        3'd2:    per_dout = dst_reg;
        3'd3:    per_dout = cnt_reg;
        3'd4:    per_dout = remain;
        default: per_dout = 16'h0000;
      endcase
    end
  end

  // Hardware DONE/ERR sets come after the software clears so a same-cycle set wins.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ie         <= 1'b0;
      src_inc    <= 1'b0;
      dst_inc    <= 1'b0;
      prio       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      abort_pend <= 1'b0;
      src_reg    <= 16'h0000;
      dst_reg    <= 16'h0000;
      cnt_reg    <= 16'h0000;
      src_w      <= 16'h0000;
      dst_w      <= 16'h0000;
      remain     <= 16'h0000;
      dma_en     <= 1'b0;
      dma_we     <= 2'b00;
      dma_addr   <= 15'h0000;
      dma_din    <= 16'h0000;
    end else begin
      if (ctrl_wr_lo) begin
        ie      <= per_din[1];
        src_inc <= per_din[2];
        dst_inc <= per_din[3];
        prio    <= per_din[5];
      end
      if (ctrl_wr_hi) begin
        if (per_din[9])  done <= 1'b0;
        if (per_din[10]) err  <= 1'b0;
      end
      if (reg_sel && !busy) begin
        case (reg_off)
          3'd1:    src_reg <= wmerge(src_reg, per_din, per_we);
          3'd2:    dst_reg <= wmerge(dst_reg, per_din, per_we);
          3'd3:    cnt_reg <= wmerge(cnt_reg, per_din, per_we);
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            if (cnt_reg != 16'h0000) begin
              src_w      <= src_reg;
              dst_w      <= dst_reg;
              remain     <= cnt_reg;
              busy       <= 1'b1;
              abort_pend <= 1'b0;
              dma_addr   <= src_reg[15:1];
              dma_we     <= 2'b00;
              dma_en     <= !dbg_freeze;
              state      <= RD;
            end else begin
              done <= 1'b1;
            end
          end
        end

        RD: begin
          if (abort_req) abort_pend <= 1'b1;
          if (!dma_en) begin
            if (halt) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (!dbg_freeze) begin
              dma_en <= 1'b1;
            end
          end else if (dma_ready) begin
            dma_en <= 1'b0;
            if (dma_resp) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (halt) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= RDCAP;
            end
          end
        end

        RDCAP: begin
          if (halt) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dma_addr <= dst_w[15:1];
            dma_din  <= byte_mode ? {rd_byte, rd_byte} : dma_dout;
            dma_we   <= byte_mode ? (dst_w[0] ? 2'b10 : 2'b01) : 2'b11;
            dma_en   <= !dbg_freeze;
            state    <= WR;
          end
        end

        WR: begin
          if (abort_req) abort_pend <= 1'b1;
          if (!dma_en) begin
            if (halt) begin
              busy   <= 1'b0;
              dma_we <= 2'b00;
              state  <= IDLE;
            end else if (!dbg_freeze) begin
              dma_en <= 1'b1;
            end
          end else if (dma_ready) begin
            dma_en <= 1'b0;
            dma_we <= 2'b00;
            if (dma_resp) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              remain <= remain - 16'd1;
              src_w  <= src_next;
              dst_w  <= dst_next;
              if (halt) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else if (remain == 16'd1) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                dma_addr <= src_next[15:1];
                dma_en   <= !dbg_freeze;
                state    <= RD;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_dma_ctrl.sv
// tb/tb_omsp_dma_ctrl.sv - scoreboard bench for omsp_dma_ctrl with a byte-addressed memory responder
module tb_omsp_dma_ctrl;
  localparam logic [15:0] BASE = 16'h0090;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        dbg_freeze;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic [15:0] dma_dout = 16'h0000;
  logic        dma_ready;
  logic        dma_resp;
  logic        irq_dma;

  always #5 mclk = ~mclk;

  omsp_dma_ctrl #(.BASE_ADDR(15'h0090)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout), .dbg_freeze(dbg_freeze),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
    .dma_priority(dma_priority), .dma_dout(dma_dout), .dma_ready(dma_ready),
    .dma_resp(dma_resp), .irq_dma(irq_dma)
  );

  // Memory responder: ready after wait_cycles, read data one cycle after ready.
  logic [7:0] mem [0:65535];
  int wait_cycles = 0;
  int wcnt = 0;
  int rd_idx = 0;
  int err_rd_idx = -1;

  assign dma_ready = dma_en && (wcnt >= wait_cycles);
  assign dma_resp  = dma_ready && (dma_we == 2'b00) && (rd_idx == err_rd_idx);

  always @(posedge mclk) begin
    wcnt <= (dma_en && !dma_ready) ? wcnt + 1 : 0;
    if (dma_ready && dma_we == 2'b00) begin
      rd_idx   <= rd_idx + 1;
      dma_dout <= {mem[{dma_addr, 1'b1}], mem[{dma_addr, 1'b0}]};
    end
    if (dma_ready && dma_we[0]) mem[{dma_addr, 1'b0}] <= dma_din[7:0];
    if (dma_ready && dma_we[1]) mem[{dma_addr, 1'b1}] <= dma_din[15:8];
  end

  // Scoreboard
  logic [32:0] exp_q [$];
  int n_pass = 0, n_total = 0;
  int rd_cnt = 0, wr_cnt = 0, en_cyc = 0;

  always @(negedge mclk) begin
    if (dma_en) en_cyc++;
    if (dma_en && dma_ready) begin
      if (dma_we == 2'b00) begin
        rd_cnt++;
      end else begin
        wr_cnt++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL wr_unexpected: got addr=%h data=%h we=%b, expected no write", dma_addr, dma_din, dma_we);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({dma_addr, dma_din, dma_we} === e) n_pass++;
          else $display("FAIL wr_txn: got addr=%h data=%h we=%b, expected addr=%h data=%h we=%b",
                        dma_addr, dma_din, dma_we, e[32:18], e[17:2], e[1:0]);
        end
      end
    end
  end

  task automatic push_wr(input logic [15:0] byte_addr, input logic [15:0] d, input logic [1:0] we);
    exp_q.push_back({byte_addr[15:1], d, we});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_word(input logic [15:0] a, input logic [15:0] v);
    mem[{a[15:1], 1'b0}] <= v[7:0];
    mem[{a[15:1], 1'b1}] <= v[15:8];
  endtask

  task automatic per_write(input logic [3:0] off, input logic [15:0] d);
    @(posedge mclk); #1;
    per_en   = 1'b1;
    per_addr = 14'((BASE + 16'(off)) >> 1);
    per_din  = d;
    per_we   = 2'b11;
    @(posedge mclk); #1;
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic per_read(input logic [3:0] off, output logic [15:0] d);
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = 14'((BASE + 16'(off)) >> 1);
    #1;
    d = per_dout;
    per_en = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] off, input logic [15:0] exp);
    logic [15:0] v;
    per_read(off, v);
    check(name, 32'(v), 32'(exp));
  endtask

  task automatic wait_idle(input string name);
    logic [15:0] c;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge mclk); #1;
      per_read(4'h0, c);
      if (!c[8]) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_write_active(input string name, input int prior_writes);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge mclk); #1;
      if (dma_en && dma_we != 2'b00 && wr_cnt == prior_writes) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int b_rd, b_wr, b_en, e0;
    reset_n = 1'b0; per_en = 1'b0; per_addr = '0; per_din = '0; per_we = 2'b00; dbg_freeze = 1'b0;
    repeat (3) @(posedge mclk); #1;
    check("rst_dma_en", 32'(dma_en), 32'd0);
    check("rst_irq", 32'(irq_dma), 32'd0);
    check("rst_dma_we", 32'(dma_we), 32'd0);
    reset_n = 1'b1;
    check_reg("rst_ctrl", 4'h0, 16'h0000);
    check_reg("rst_remain", 4'h8, 16'h0000);

    // Word copy, zero-wait
    set_word(16'h0200, 16'h1111); set_word(16'h0202, 16'h2222);
    set_word(16'h0204, 16'h3333); set_word(16'h0206, 16'h4444);
    per_write(4'h2, 16'h0200); per_write(4'h4, 16'h0300); per_write(4'h6, 16'd4);
    push_wr(16'h0300, 16'h1111, 2'b11); push_wr(16'h0302, 16'h2222, 2'b11);
    push_wr(16'h0304, 16'h3333, 2'b11); push_wr(16'h0306, 16'h4444, 2'b11);
    b_rd = rd_cnt; b_wr = wr_cnt;
    per_write(4'h0, 16'h000D);
    check("t1_en_n1", 32'(dma_en), 32'd1);
    check("t1_addr_n1", 32'(dma_addr), 32'h0100);
    check("t1_prio_n1", 32'(dma_priority), 32'd0);
    repeat (11) @(posedge mclk); #1;
    check_reg("t1_busy_n12", 4'h0, 16'h010C);
    @(posedge mclk); #1;
    check_reg("t1_done_n13", 4'h0, 16'h020C);
    check("t1_reads", 32'(rd_cnt - b_rd), 32'd4);
    check("t1_writes", 32'(wr_cnt - b_wr), 32'd4);
    check_reg("t1_remain", 4'h8, 16'h0000);
    check_reg("t1_src_kept", 4'h2, 16'h0200);
    check_reg("t1_unmapped_a", 4'hA, 16'h0000);
    check("t1_mem_0306", 32'({mem[16'h0307], mem[16'h0306]}), 32'h4444);
    per_addr = 14'((BASE + 16'd2) >> 1); #1;
    check("t1_dout_unsel", 32'(per_dout), 32'h0000);
    per_write(4'h0, 16'h0200);

    // CNT=0 start
    per_write(4'h6, 16'd0);
    b_en = en_cyc;
    per_write(4'h0, 16'h0003);
    check_reg("t2_done", 4'h0, 16'h0202);
    check("t2_irq", 32'(irq_dma), 32'd1);
    per_write(4'h0, 16'h0200);
    check("t2_irq_clr", 32'(irq_dma), 32'd0);
    check_reg("t2_ctrl_clr", 4'h0, 16'h0000);
    check("t2_no_en", 32'(en_cyc - b_en), 32'd0);

    // Error on second read
    set_word(16'h0500, 16'hA001); set_word(16'h0502, 16'hA002);
    per_write(4'h2, 16'h0500); per_write(4'h4, 16'h0600); per_write(4'h6, 16'd5);
    err_rd_idx = rd_idx + 1;
    push_wr(16'h0600, 16'hA001, 2'b11);
    b_wr = wr_cnt;
    per_write(4'h0, 16'h000D);
    wait_idle("t3_idle");
    check_reg("t3_err", 4'h0, 16'h040C);
    check_reg("t3_remain", 4'h8, 16'd4);
    e0 = en_cyc;
    repeat (10) @(posedge mclk); #1;
    check("t3_no_en", 32'(en_cyc - e0), 32'd0);
    check("t3_writes", 32'(wr_cnt - b_wr), 32'd1);
    err_rd_idx = -1;
    per_write(4'h0, 16'h0400);
    check_reg("t3_err_clr", 4'h0, 16'h0000);

    // Wait states and abort during the second write
    wait_cycles = 3;
    set_word(16'h0700, 16'hB001); set_word(16'h0702, 16'hB002);
    set_word(16'h0704, 16'hB003); set_word(16'h0706, 16'hB004);
    per_write(4'h2, 16'h0700); per_write(4'h4, 16'h0800); per_write(4'h6, 16'd4);
    push_wr(16'h0800, 16'hB001, 2'b11); push_wr(16'h0802, 16'hB002, 2'b11);
    b_wr = wr_cnt;
    per_write(4'h0, 16'h000D);
    wait_write_active("t4_second_wr", b_wr + 1);
    per_write(4'h0, 16'h004C);
    check("t4_en_held", 32'(dma_en), 32'd1);
    wait_idle("t4_idle");
    check_reg("t4_ctrl", 4'h0, 16'h000C);
    check_reg("t4_remain", 4'h8, 16'd2);
    e0 = en_cyc;
    repeat (10) @(posedge mclk); #1;
    check("t4_no_en", 32'(en_cyc - e0), 32'd0);
    check("t4_writes", 32'(wr_cnt - b_wr), 32'd2);
    wait_cycles = 0;

    // Debugger freeze between units, with priority
    set_word(16'h0900, 16'hC001); set_word(16'h0902, 16'hC002); set_word(16'h0904, 16'hC003);
    per_write(4'h2, 16'h0900); per_write(4'h4, 16'h0A00); per_write(4'h6, 16'd3);
    push_wr(16'h0A00, 16'hC001, 2'b11); push_wr(16'h0A02, 16'hC002, 2'b11);
    push_wr(16'h0A04, 16'hC003, 2'b11);
    b_wr = wr_cnt;
    per_write(4'h0, 16'h002D);
    wait_write_active("t5_first_wr", b_wr);
    check("t5_prio", 32'(dma_priority), 32'd1);
    dbg_freeze = 1'b1;
    @(posedge mclk); #1;
    check("t5_en_frozen", 32'(dma_en), 32'd0);
    e0 = en_cyc;
    repeat (9) @(posedge mclk); #1;
    check("t5_no_en_freeze", 32'(en_cyc - e0), 32'd0);
    dbg_freeze = 1'b0;
    wait_idle("t5_idle");
    check_reg("t5_done", 4'h0, 16'h022C);
    check("t5_writes", 32'(wr_cnt - b_wr), 32'd3);
    check("t5_mem_0a04", 32'({mem[16'h0A05], mem[16'h0A04]}), 32'hC003);
    per_write(4'h0, 16'h0200);

`ifdef OMSP_DMA_BYTE_MODE_EN
    set_word(16'h0200, 16'hBBAA); set_word(16'h0202, 16'hDDCC);
    per_write(4'h2, 16'h0201); per_write(4'h4, 16'h0400); per_write(4'h6, 16'd3);
    push_wr(16'h0400, 16'hBBBB, 2'b01); push_wr(16'h0400, 16'hCCCC, 2'b10);
    push_wr(16'h0402, 16'hDDDD, 2'b01);
    per_write(4'h0, 16'h001D);
    wait_idle("t6_idle");
    check_reg("t6_done", 4'h0, 16'h021C);
    check("t6_mem_bytes", 32'({mem[16'h0402], mem[16'h0401], mem[16'h0400]}), 32'h00DDCCBB);
`else
    set_word(16'h0200, 16'hBBAA);
    per_write(4'h2, 16'h0201); per_write(4'h4, 16'h0401); per_write(4'h6, 16'd1);
    push_wr(16'h0400, 16'hBBAA, 2'b11);
    per_write(4'h0, 16'h001D);
    wait_idle("t6_idle");
    check_reg("t6_done_nobyte", 4'h0, 16'h020C);
    check("t6_mem_word", 32'({mem[16'h0401], mem[16'h0400]}), 32'h0000BBAA);
`endif
    per_write(4'h0, 16'h0200);

    // Reset in mid-transfer
    wait_cycles = 3;
    per_write(4'h2, 16'h0700); per_write(4'h4, 16'h0800); per_write(4'h6, 16'd2);
    per_write(4'h0, 16'h000D);
    check("t7_en_before", 32'(dma_en), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("t7_en_async", 32'(dma_en), 32'd0);
    @(posedge mclk); #1;
    reset_n = 1'b1;
    wait_cycles = 0;
    check_reg("t7_ctrl", 4'h0, 16'h0000);
    check_reg("t7_src", 4'h2, 16'h0000);
    repeat (5) @(posedge mclk); #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/omsp_dma_ctrl.md
# omsp_dma_ctrl

Memory-to-memory DMA controller for the openMSP430 system. It is programmed by the CPU through the peripheral bus and moves blocks of words or bytes between any two addresses in the 64 KB map by driving the core's DMA port. It sequences each transfer as a read handshake followed by a write handshake and raises a completion interrupt. It sits beside the GPIO, timer and UART peripherals: its `per_dout` is ORed into the shared peripheral read bus and `irq_dma` is wired to a free interrupt vector.

## Interface
Parameters:
- `BASE_ADDR`, 15'h0090: byte base address of the 16-byte register window; the window is 16-byte aligned.

Ports (clock and reset first):
- `mclk` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `per_addr` in 14: peripheral word address.
- `per_din` in 16: peripheral write data.
- `per_en` in 1: peripheral enable.
- `per_we` in 2: peripheral byte write enables.
- `per_dout` out 16: register read data; 0 when not selected.
- `dbg_freeze` in 1: debugger freeze.
- `dma_addr` out 15: DMA word address, carried as bits [15:1].
- `dma_din` out 16: DMA write data.
- `dma_en` out 1: DMA access request.
- `dma_we` out 2: DMA byte write enables; 00 means read.
- `dma_priority` out 1: DMA priority.
- `dma_dout` in 16: DMA read data.
- `dma_ready` in 1: access accepted this cycle.
- `dma_resp` in 1: access error, qualified by `dma_ready`.
- `irq_dma` out 1: completion interrupt, level.

## Operation
Register selection:
- Selected when `per_en` is high and `per_addr[13:3] == BASE_ADDR[14:4]`.
- The word offset is `per_addr[2:0]`.
- Writes are byte-granular per `per_we`.

Registers (byte offset):
- 0x0 CTRL (R/W):
  - bit0 START: write 1 to start; self-clearing; reads 0.
  - bit1 IE, bit2 SRC_INC, bit3 DST_INC, bit4 BYTE, bit5 PRIO.
  - bit6 ABORT: write 1 to abort; reads 0.
  - bit8 BUSY: read-only.
  - bit9 DONE and bit10 ERR: write 1 to clear.
- 0x2 SRC, 0x4 DST, 0x6 CNT: 16-bit byte addresses and transfer count. Writes to these are ignored while BUSY.
- 0x8 REMAIN: read-only live count. Offsets 0xA–0xE read 0.

Reset values:
- All registers 0.
- `dma_en`=0, `dma_we`=00, `dma_addr`=0, `dma_din`=0, `dma_priority`=0, `irq_dma`=0.

State machine: IDLE, RD, RDCAP, WR.
- IDLE: on a START write with CNT≠0, load the working address and count registers from SRC/DST/CNT, set BUSY and go to RD. On a START write with CNT=0, set DONE next cycle with no bus access. START is ignored while BUSY.
- RD: `dma_en`=1, `dma_we`=00, `dma_addr`=src[15:1]. Hold until `dma_ready`.
  - `dma_ready` with `dma_resp`=1: set ERR, clear BUSY, go to IDLE.
  - Otherwise go to RDCAP.
- RDCAP: latch `dma_dout`, which is valid the cycle after a read `dma_ready`. Go to WR.
- WR: `dma_en`=1, `dma_addr`=dst[15:1], `dma_din`=latched data, `dma_we`=11 (word mode). Hold until `dma_ready`.
  - Error response: same handling as RD.
  - Otherwise decrement REMAIN and apply the address increments. If REMAIN was 1: set DONE, clear BUSY, go to IDLE. Else go to RD.

Address rules:
- Word mode: increment is +2; address bit0 is ignored.
- Byte mode: increment is +1; the byte is selected by src[0]; `dma_din`={b,b}; `dma_we` is 10 if dst[0]=1, else 01.
- Addresses wrap modulo 2^16.
- SRC/DST registers keep their programmed values; the working copies are internal.

Other behaviour:
- ABORT while BUSY: finish the current handshake, then go to IDLE with BUSY=0; DONE is not set.
- ABORT in IDLE has no effect.
- `dbg_freeze`=1: no new access is started from RD/WR entry. An outstanding `dma_en` is held until `dma_ready`.
- `dma_priority` = PRIO while `dma_en`=1, else 0.
- `irq_dma` = IE & (DONE | ERR).
- If the hardware sets DONE or ERR in the same cycle software clears it, the set wins.
- Reset in mid-transfer: immediate return to IDLE with the reset values; `dma_en` drops asynchronously.

## Timing
- Register write at cycle N takes effect at N+1. `per_dout` is combinational from `per_en`/`per_addr`.
- START write at cycle N: `dma_en` is high at N+1.
- With zero-wait `dma_ready`, each unit takes 3 cycles (RD, RDCAP, WR).
- DONE, BUSY=0 and `irq_dma` are visible the cycle after the last write's `dma_ready`.
- `dma_addr`, `dma_we` and `dma_din` are stable while `dma_en`=1 and `dma_ready`=0.

## Configuration
- Macro: `OMSP_DMA_BYTE_MODE_EN`.
- Defined: the BYTE bit is implemented with the byte-mode behaviour above.
- Undefined: BYTE reads 0 and writes to it are ignored. All transfers are word transfers, the increment is +2, and `dma_we` is always 11 on writes.

## Test plan
- SRC=0x0200, DST=0x0300, CNT=4, word mode, both INC set, `dma_ready` tied 1 -> 4 reads then 4 writes, alternating. Data at 0x0300–0x0306 matches the source. DONE=1 at 12 cycles after the START cycle + 1.
- Byte mode, SRC=0x0201, DST=0x0400, CNT=3 -> source bytes 0x0201–0x0203 land at 0x0400–0x0402. Write `dma_we` sequence is 01, 10, 01.
- CNT=0 with START, IE=1 -> no `dma_en` pulse; DONE=1 and `irq_dma`=1 at N+1. Writing 0x0200 to CTRL clears `irq_dma`.
- `dma_resp`=1 on the 2nd read of a CNT=5 transfer -> ERR=1, BUSY=0, REMAIN=4, no further `dma_en`.
- `dma_ready` delayed 3 cycles each, with ABORT mid-write -> `dma_en` is held until ready, then IDLE. DONE=0 and REMAIN equals the pending count minus 1.
- `dbg_freeze` pulsed for 10 cycles between units -> no `dma_en` during the freeze; the transfer then completes with correct data.
